// File: rtl/audio_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_out_buffer
// Brief    : Mono sample FIFO feeding a stereo codec write port, with sticky
//            overflow/underrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module audio_out_buffer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     write_ready,
    output logic                     write,
    output logic [DATA_W-1:0]        writedata_left,
    output logic [DATA_W-1:0]        writedata_right,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_COUNT_W = c_ADDR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_COUNT_W-1:0] r_count;
    state_t               r_state;
    logic [DATA_W-1:0]    r_data;
    logic                 r_overflow;
    logic                 r_underrun;
    logic                 r_written;

    logic w_full;
    logic w_push;
    logic w_write;
    logic w_load;

    // Full is taken from the registered count only, so in_ready never sees write_ready.
    assign w_full  = (r_count == c_COUNT_W'(DEPTH));
    assign w_push  = in_valid && !w_full;
    assign w_write = (r_state == S_HOLD) && write_ready;
    assign w_load  = (r_count != '0) && ((r_state == S_IDLE) || w_write);

    assign in_ready        = !w_full;
    assign write           = w_write;
    assign writedata_left  = r_data;
    assign writedata_right = r_data;
    assign fill_level      = r_count;
    assign overflow        = r_overflow;
    assign underrun        = r_underrun;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register FSM: a load both fills the register and keeps/enters HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_load) begin
                        r_data <= r_mem[r_rd_ptr];
                    end else if (w_write) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
            r_written  <= 1'b0;
        end else begin
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_write) begin
                r_written <= 1'b1;
            end
            if ((r_state == S_IDLE) && write_ready && r_written) begin
                r_underrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
